// File: rtl/pc_push_ctrl_pkg.sv
// pc_push_ctrl_pkg: shared processor definitions for the PC/flags push controller
// Contents:
//   ADDR_W      data-memory address width
//   CALL_WORDS  stack words pushed by a CALL (PC high, PC low)
//   INT_WORDS   stack words pushed by an interrupt (PC high, PC low, flags)
//   push_state_t  push FSM state encoding
package pc_push_ctrl_pkg;
    localparam int ADDR_W     = 20;
    localparam int CALL_WORDS = 2;
    localparam int INT_WORDS  = 3;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH_HI  = 3'd1,
        PUSH_LO  = 3'd2,
        PUSH_FLG = 3'd3,
        DONE     = 3'd4
    } push_state_t;
endpackage

// File: rtl/pc_push_ctrl.sv
// pc_push_ctrl: pushes the PC (and flags on interrupt) onto the data-memory stack
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   call_req, int_req push requests, held high until done; interrupt wins a tie
//   pc_in             PC to save; flags_in CCR flags (interrupt only); sp_in stack pointer
//   mem_wr_en, mem_addr, mem_wr_data  data-memory write port
//   sp_out, sp_we     stack-pointer write-back
//   stall_fetch       high whenever a push is in progress
//   done              one-cycle completion pulse
module pc_push_ctrl #(
    parameter int ADDR_W = pc_push_ctrl_pkg::ADDR_W,
    parameter int SP_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              call_req,
    input  logic              int_req,
    input  logic [31:0]       pc_in,
    input  logic [2:0]        flags_in,
    input  logic [SP_W-1:0]   sp_in,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wr_data,
    output logic [SP_W-1:0]   sp_out,
    output logic              sp_we,
    output logic              stall_fetch,
    output logic              done
);
    import pc_push_ctrl_pkg::*;

    push_state_t     state, next;
    logic [31:0]     pc_r;
    logic [2:0]      flg_r;
    logic [SP_W-1:0] sp_r;
    logic            is_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc_r   <= '0;
            flg_r  <= '0;
            sp_r   <= '0;
            is_int <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && (int_req || call_req)) begin
                pc_r   <= pc_in;
                flg_r  <= flags_in;
                sp_r   <= sp_in;
                is_int <= int_req;
            end
        end
    end

    always_comb begin
        next        = state;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        sp_out      = '0;
        sp_we       = 1'b0;
        done        = 1'b0;
        stall_fetch = state != IDLE;
        case (state)
            IDLE: next = (int_req || call_req) ? PUSH_HI : IDLE;
            PUSH_HI: begin
                mem_wr_en   = 1'b1;
                mem_addr    = sp_r[ADDR_W-1:0];
                mem_wr_data = pc_r[31:16];
                next        = PUSH_LO;
            end
            PUSH_LO: begin
                mem_wr_en   = 1'b1;
                mem_addr    = ADDR_W'(sp_r - SP_W'(1));
                mem_wr_data = pc_r[15:0];
                next        = is_int ? PUSH_FLG : DONE;
            end
            PUSH_FLG: begin
                mem_wr_en   = 1'b1;
                mem_addr    = ADDR_W'(sp_r - SP_W'(2));
                mem_wr_data = {13'b0, flg_r};
                next        = DONE;
            end
            DONE: begin
                done   = 1'b1;
                sp_we  = 1'b1;
                sp_out = sp_r - (is_int ? SP_W'(INT_WORDS) : SP_W'(CALL_WORDS));
                next   = IDLE;
            end
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pc_push_ctrl.sv
// tb_pc_push_ctrl: directed self-checking bench for pc_push_ctrl
module tb_pc_push_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        call_req = 1'b0;
    logic        int_req = 1'b0;
    logic [31:0] pc_in = '0;
    logic [2:0]  flags_in = '0;
    logic [31:0] sp_in = '0;
    logic        mem_wr_en;
    logic [19:0] mem_addr;
    logic [15:0] mem_wr_data;
    logic [31:0] sp_out;
    logic        sp_we;
    logic        stall_fetch;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int we_cnt = 0;

    pc_push_ctrl dut (
        .clk(clk), .rst(rst), .call_req(call_req), .int_req(int_req),
        .pc_in(pc_in), .flags_in(flags_in), .sp_in(sp_in),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .sp_out(sp_out), .sp_we(sp_we), .stall_fetch(stall_fetch), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (sp_we) we_cnt <= we_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic en, input logic [19:0] addr,
                        input logic [15:0] data, input logic we, input logic [31:0] spo,
                        input logic dn, input logic st);
        chk({tag, ".wr_en"}, 32'(mem_wr_en), 32'(en));
        chk({tag, ".addr"}, 32'(mem_addr), 32'(addr));
        chk({tag, ".wdata"}, 32'(mem_wr_data), 32'(data));
        chk({tag, ".sp_we"}, 32'(sp_we), 32'(we));
        chk({tag, ".sp_out"}, sp_out, spo);
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".stall"}, 32'(stall_fetch), 32'(st));
    endtask

    task automatic window(input logic use_int, input int exp_win, input int exp_wr);
        int win, w0, d0;
        logic seen;
        win = 0;
        seen = 1'b0;
        w0 = wr_cnt;
        d0 = done_cnt;
        sp_in = 32'h0000_0200;
        pc_in = 32'hCAFE_F00D;
        flags_in = 3'b011;
        if (use_int) int_req = 1'b1; else call_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (call_req || int_req || stall_fetch) win++;
            if (done) begin
                seen = 1'b1;
                call_req = 1'b0;
                int_req = 1'b0;
            end
            step();
        end
        chk(use_int ? "win_int.done_seen" : "win_call.done_seen", 32'(seen), 32'd1);
        chk(use_int ? "win_int.cycles" : "win_call.cycles", win, exp_win);
        chk(use_int ? "win_int.writes" : "win_call.writes", wr_cnt - w0, exp_wr);
        chk(use_int ? "win_int.dones" : "win_call.dones", done_cnt - d0, 1);
    endtask

    initial begin
        int w0, d0, s0;
        @(negedge clk);
        step();
        outs("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        outs("idle", 0, 0, 0, 0, 0, 0, 0);

        // CALL from top of memory
        sp_in = 32'h000F_FFFF; pc_in = 32'h0001_2345; call_req = 1'b1;
        step();
        pc_in = 32'hDEAD_BEEF; sp_in = 32'h1234_5678;
        outs("call.hi", 1, 20'hFFFFF, 16'h0001, 0, 0, 0, 1);
        step();
        outs("call.lo", 1, 20'hFFFFE, 16'h2345, 0, 0, 0, 1);
        step();
        outs("call.done", 0, 0, 0, 1, 32'h000F_FFFD, 1, 1);
        call_req = 1'b0;
        step();
        outs("call.idle", 0, 0, 0, 0, 0, 0, 0);

        // interrupt
        sp_in = 32'h0000_0100; pc_in = 32'h0000_0040; flags_in = 3'b101; int_req = 1'b1;
        step();
        flags_in = 3'b010; pc_in = 32'hFFFF_FFFF;
        outs("int.hi", 1, 20'h00100, 16'h0000, 0, 0, 0, 1);
        step();
        outs("int.lo", 1, 20'h000FF, 16'h0040, 0, 0, 0, 1);
        step();
        outs("int.flg", 1, 20'h000FE, 16'h0005, 0, 0, 0, 1);
        step();
        outs("int.done", 0, 0, 0, 1, 32'h0000_00FD, 1, 1);
        int_req = 1'b0;
        step();
        outs("int.idle", 0, 0, 0, 0, 0, 0, 0);

        // simultaneous: interrupt first, pending CALL follows on the written-back SP
        sp_in = 32'h0000_0100; pc_in = 32'h0000_0040; flags_in = 3'b101;
        int_req = 1'b1; call_req = 1'b1;
        step();
        outs("both.hi", 1, 20'h00100, 16'h0000, 0, 0, 0, 1);
        step();
        outs("both.lo", 1, 20'h000FF, 16'h0040, 0, 0, 0, 1);
        step();
        outs("both.flg", 1, 20'h000FE, 16'h0005, 0, 0, 0, 1);
        step();
        outs("both.done", 0, 0, 0, 1, 32'h0000_00FD, 1, 1);
        int_req = 1'b0; sp_in = 32'h0000_00FD; pc_in = 32'h1234_5678;
        step();
        outs("both.gap", 0, 0, 0, 0, 0, 0, 0);
        step();
        outs("both.call_hi", 1, 20'h000FD, 16'h1234, 0, 0, 0, 1);
        step();
        outs("both.call_lo", 1, 20'h000FC, 16'h5678, 0, 0, 0, 1);
        step();
        outs("both.call_done", 0, 0, 0, 1, 32'h0000_00FB, 1, 1);
        call_req = 1'b0;
        step();
        outs("both.idle", 0, 0, 0, 0, 0, 0, 0);

        // SP wrap at zero
        sp_in = 32'h0000_0000; pc_in = 32'hA5A5_5A5A; call_req = 1'b1;
        step();
        outs("wrap.hi", 1, 20'h00000, 16'hA5A5, 0, 0, 0, 1);
        step();
        outs("wrap.lo", 1, 20'hFFFFF, 16'h5A5A, 0, 0, 0, 1);
        step();
        outs("wrap.done", 0, 0, 0, 1, 32'hFFFF_FFFE, 1, 1);
        call_req = 1'b0;
        step();

        // reset during PUSH_LO of an interrupt
        sp_in = 32'h0000_0800; pc_in = 32'h0BAD_F00D; flags_in = 3'b111; int_req = 1'b1;
        step();
        step();
        outs("abort.lo", 1, 20'h007FF, 16'hF00D, 0, 0, 0, 1);
        rst = 1'b1; int_req = 1'b0;
        step();
        outs("abort.rst", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        w0 = wr_cnt; d0 = done_cnt; s0 = we_cnt;
        for (int i = 0; i < 6; i++) step();
        chk("abort.stray_wr", wr_cnt - w0, 0);
        chk("abort.stray_done", done_cnt - d0, 0);
        chk("abort.stray_spwe", we_cnt - s0, 0);
        outs("abort.idle", 0, 0, 0, 0, 0, 0, 0);

        // requester holds the request through done, then drops it
        window(1'b0, 4, 2);
        window(1'b1, 5, 3);
        outs("final.idle", 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
